block_lock_ctrl: RTL and testbench

BLOCK_LOCK_CTRL -- requirements
Module: block_lock_ctrl

---
 rtl/block_lock_ctrl.sv | 149 ++++++++++++++
 tb/tb_block_lock_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/block_lock_ctrl.sv
// Sync-header block lock controller: HUNT / SLIP / LOCKED with windowed error monitor.
// Optional saturating header-error counter enabled by defining BLOCK_LOCK_CTRL_ERR_CNT_EN.
module block_lock_ctrl #(
    parameter int LOCK_CNT      = 64,
    parameter int WIN_SIZE      = 64,
    parameter int ERR_LIMIT     = 16,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_390p625M,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [1:0]               rx_sync_hdr,
    input  logic                     slip_ack,
    output logic                     descrambler_en,
    output logic                     block_lock,
    output logic                     slip_req,
    output logic [ERR_CNT_WIDTH-1:0] hdr_err_cnt
);

    localparam int CNT_MAX = (LOCK_CNT > WIN_SIZE) ? LOCK_CNT : WIN_SIZE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOCK_C = CW'(LOCK_CNT);
    localparam logic [CW-1:0] WIN_C  = CW'(WIN_SIZE);
    localparam logic [CW-1:0] ERR_C  = CW'(ERR_LIMIT);
    // A limit larger than the window can never be reached before the window clears.
    localparam bit ERR_REACHABLE = (ERR_LIMIT <= WIN_SIZE);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_sh_cnt;
    logic [CW-1:0]   r_win_cnt;
    logic [CW-1:0]   r_bad_cnt;
    logic [CW-1:0]   w_sh_next;
    logic [CW-1:0]   w_win_next;
    logic [CW-1:0]   w_bad_next;
    logic [CW-1:0]   w_sh_inc;
    logic [CW-1:0]   w_win_inc;
    logic [CW-1:0]   w_bad_inc;
    logic            w_hdr_ok;
    logic            w_bad_hit;
    logic            r_block_lock;
    logic            r_slip_req;

    assign w_hdr_ok  = rx_sync_hdr[1] ^ rx_sync_hdr[0];
    assign w_sh_inc  = r_sh_cnt + CW'(1);
    assign w_win_inc = r_win_cnt + CW'(1);
    assign w_bad_inc = r_bad_cnt + CW'(!w_hdr_ok);
    assign w_bad_hit = ERR_REACHABLE && !w_hdr_ok && (w_bad_inc == ERR_C);

    always_comb begin
        w_next_state = r_state;
        w_sh_next    = r_sh_cnt;
        w_win_next   = r_win_cnt;
        w_bad_next   = r_bad_cnt;
        case (r_state)
            HUNT: begin
                if (rx_valid) begin
                    if (w_hdr_ok) begin
                        if (w_sh_inc == LOCK_C) begin
                            w_next_state = LOCKED;
                            w_sh_next    = '0;
                            w_win_next   = '0;
                            w_bad_next   = '0;
                        end else begin
                            w_sh_next = w_sh_inc;
                        end
                    end else begin
                        w_sh_next    = '0;
                        w_next_state = SLIP;
                    end
                end
            end
            SLIP: begin
                if (slip_ack) begin
                    w_next_state = HUNT;
                    w_sh_next    = '0;
                end
            end
            LOCKED: begin
                // Loss of lock is checked before the window boundary so it wins a tie.
                if (rx_valid) begin
                    if (w_bad_hit) begin
                        w_next_state = SLIP;
                        w_win_next   = '0;
                        w_bad_next   = '0;
                    end else if (w_win_inc == WIN_C) begin
                        w_win_next = '0;
                        w_bad_next = '0;
                    end else begin
                        w_win_next = w_win_inc;
                        w_bad_next = w_bad_inc;
                    end
                end
            end
            default: begin
                w_next_state = HUNT;
                w_sh_next    = '0;
                w_win_next   = '0;
                w_bad_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_sh_cnt     <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            r_block_lock <= 1'b0;
            r_slip_req   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_sh_cnt     <= w_sh_next;
            r_win_cnt    <= w_win_next;
            r_bad_cnt    <= w_bad_next;
            r_block_lock <= (w_next_state == LOCKED);
            r_slip_req   <= (w_next_state == SLIP);
        end
    end

    assign block_lock     = r_block_lock;
    assign slip_req       = r_slip_req;
    assign descrambler_en = rx_valid & r_block_lock;

`ifdef BLOCK_LOCK_CTRL_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_hdr_err_cnt;

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_err_cnt <= '0;
        end else if ((r_state == LOCKED) && rx_valid && !w_hdr_ok && (r_hdr_err_cnt != '1)) begin
            r_hdr_err_cnt <= r_hdr_err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

    assign hdr_err_cnt = r_hdr_err_cnt;
`else
    assign hdr_err_cnt = '0;
`endif

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Directed bench for block_lock_ctrl: lock acquisition, slip handshake, window monitor, reset, error counter.
`timescale 1ns/1ps
module tb_block_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [1:0] rx_sync_hdr;
    logic       slip_ack;

    logic       desc_en1, lock1, slip1;
    logic [7:0] err1;
    logic       desc_en2, lock2, slip2;
    logic [3:0] err2;

    int n_checks = 0;
    int n_errors = 0;

`ifdef BLOCK_LOCK_CTRL_ERR_CNT_EN
    localparam int EXP_ERR1 = 16;
    localparam int EXP_ERR2 = 15;
`else
    localparam int EXP_ERR1 = 0;
    localparam int EXP_ERR2 = 0;
`endif

    always #5 clk = ~clk;

    block_lock_ctrl u_dut (
        .clk_390p625M   (clk),
        .rst_n          (rst_n),
        .rx_valid       (rx_valid),
        .rx_sync_hdr    (rx_sync_hdr),
        .slip_ack       (slip_ack),
        .descrambler_en (desc_en1),
        .block_lock     (lock1),
        .slip_req       (slip1),
        .hdr_err_cnt    (err1)
    );

    block_lock_ctrl #(
        .ERR_LIMIT     (32),
        .ERR_CNT_WIDTH (4)
    ) u_dut_sat (
        .clk_390p625M   (clk),
        .rst_n          (rst_n),
        .rx_valid       (rx_valid),
        .rx_sync_hdr    (rx_sync_hdr),
        .slip_ack       (slip_ack),
        .descrambler_en (desc_en2),
        .block_lock     (lock2),
        .slip_req       (slip2),
        .hdr_err_cnt    (err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] hdr);
        @(negedge clk);
        rx_valid    = 1'b1;
        rx_sync_hdr = hdr;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [1:0] hdr);
        for (int i = 0; i < n; i++) send(hdr);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        slip_ack = 1'b1;
        @(posedge clk);
        #1;
        slip_ack = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_valid    = 1'b1;
        rx_sync_hdr = 2'b01;
        slip_ack    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lock", lock1, 0);
        check("rst_slip", slip1, 0);
        check("rst_desc", desc_en1, 0);
        check("rst_err", err1, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Acquisition with idle gap and a stray slip_ack that must be ignored
        send_n(30, 2'b01);
        idle(10);
        pulse_ack();
        check("hunt_ack_ignored", slip1, 0);
        send_n(33, 2'b10);
        check("lock_after_63", lock1, 0);
        send(2'b01);
        check("lock_after_64", lock1, 1);
        check("lock_slip", slip1, 0);

        // Window 1, block 1 used to probe descrambler_en
        @(negedge clk);
        rx_valid    = 1'b1;
        rx_sync_hdr = 2'b01;
        #1;
        check("desc_en_hi", desc_en1, 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        #1;
        check("desc_en_lo", desc_en1, 0);
        send_n(15, 2'b00);
        send_n(48, 2'b01);
        check("win1_15bad", lock1, 1);

        send_n(8, 2'b11);
        send_n(7, 2'b00);
        send_n(49, 2'b01);
        check("win2_15bad", lock1, 1);

        // 16th error lands on the final block of the window
        send_n(15, 2'b00);
        send_n(48, 2'b01);
        check("win3_blk63", lock1, 1);
        send(2'b11);
        check("win3_loss_lock", lock1, 0);
        check("win3_loss_slip", slip1, 1);

        send_n(5, 2'b01);
        idle(5);
        check("slip_ignores_rx", slip1, 1);
        pulse_ack();
        check("ack_slip", slip1, 0);
        check("ack_lock", lock1, 0);

        send_n(10, 2'b01);
        send(2'b11);
        check("hunt_bad_slip", slip1, 1);
        idle(5);
        check("slip_held", slip1, 1);
        pulse_ack();
        check("ack2_slip", slip1, 0);
        send_n(63, 2'b01);
        check("relock_63", lock1, 0);
        send(2'b01);
        check("relock_64", lock1, 1);

        send_n(16, 2'b00);
        check("loss2_lock", lock1, 0);
        check("loss2_slip", slip1, 1);

        // Asynchronous reset between clock edges while in SLIP
        @(negedge clk);
        rx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_slip", slip1, 0);
        check("arst_lock", lock1, 0);
        check("arst_desc", desc_en1, 0);
        check("arst_err1", err1, 0);
        check("arst_err2", err2, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        send_n(63, 2'b01);
        check("post_rst_63", lock1, 0);
        check("post_rst_slip", slip1, 0);
        send(2'b01);
        check("post_rst_64", lock1, 1);
        check("sat_dut_lock", lock2, 1);

        send_n(20, 2'b00);
        check("sat_dut_still_locked", lock2, 1);
        check("sat_err_cnt", err2, EXP_ERR2);
        check("dflt_err_cnt", err1, EXP_ERR1);
        check("dflt_lost", lock1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
